// File: rtl/nonce_loader_pkg.sv
// Shared definitions for the nonce framing stage: FSM states and the
// host-protocol constants that must agree with the nonce register width.
package nonce_loader_pkg;

  // Payload bytes per frame; 12 bytes fill the 96-bit nonce register.
  localparam int unsigned NONCE_BYTES_DEFAULT = 12;

  // Frame start marker, ASCII 'N'.
  localparam logic [7:0] START_BYTE_DEFAULT = 8'h4E;

  // IDLE: hunting for a start byte.
  // LOAD: forwarding payload bytes.
  // DONE: final byte forwarded; the commit strobe follows.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : nonce_loader_pkg

// File: rtl/nonce_loader.sv
// Frames raw UART bytes into a nonce load: waits for the start byte, forwards
// NONCE_BYTES payload bytes as shift strobes (first byte most significant),
// then strobes ready_o so the nonce register commits. A host that goes quiet
// mid-frame for TIMEOUT_CYCLES cycles aborts the frame with error_o.
// hold_o stays high for the whole load so the nonce is not incremented under it.
module nonce_loader
  import nonce_loader_pkg::*;
#(
  parameter int unsigned NONCE_BYTES    = NONCE_BYTES_DEFAULT,
  parameter logic [7:0]  START_BYTE     = START_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_valid_i,
  output logic [7:0] rx_byte_o,
  output logic       shift_in_o,
  output logic       ready_o,
  output logic       hold_o,
  output logic       error_o
);

  localparam int unsigned CNT_W = $clog2(NONCE_BYTES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Counter values at which the current byte / idle cycle is the last one.
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NONCE_BYTES - 1);
  localparam logic [TMO_W-1:0] LAST_IDLE = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [TMO_W-1:0] r_idle_cnt;

  logic [7:0]       r_rx_byte;
  logic             r_shift;
  logic             r_ready;
  logic             r_hold;
  logic             r_error;

  logic             w_shift_next;
  logic             w_ready_next;
  logic             w_hold_next;
  logic             w_error_next;

  // Decoded input events.
  logic w_start;
  logic w_accept;
  logic w_timeout;

  assign w_start   = rx_valid_i && (rx_byte_i == START_BYTE);
  assign w_accept  = (r_state == LOAD) && rx_valid_i;
  assign w_timeout = (r_state == LOAD) && !rx_valid_i && (r_idle_cnt == LAST_IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; DONE looks for a new start byte exactly like IDLE.
  // NOTE: the default assignment at the top keeps this block free of latches
  // on any path that does not assign.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE, DONE: w_state_next = w_start ? LOAD : IDLE;
      LOAD: begin
        if (w_accept && (r_byte_cnt == LAST_BYTE)) begin
          w_state_next = DONE;
        end else if (w_timeout) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs. hold stays up through the
  // ready/error cycle and drops on the cycle after it.
  always_comb begin
    w_shift_next = w_accept;
    w_ready_next = (r_state == DONE);
    w_error_next = w_timeout;
    w_hold_next  = (w_state_next != IDLE) || w_ready_next || w_error_next;
  end

  // Payload byte and idle counters; both are held at zero outside LOAD so a
  // new frame always starts from a clean count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_cnt <= '0;
      r_idle_cnt <= '0;
    end else if (r_state != LOAD) begin
      r_byte_cnt <= '0;
      r_idle_cnt <= '0;
    end else if (rx_valid_i) begin
      r_byte_cnt <= r_byte_cnt + CNT_W'(1);
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + TMO_W'(1);
    end
  end

  // Output registers; rx_byte_o keeps the last forwarded byte between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_byte <= '0;
      r_shift   <= 1'b0;
      r_ready   <= 1'b0;
      r_hold    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rx_byte <= rx_byte_i;
      end
      r_shift <= w_shift_next;
      r_ready <= w_ready_next;
      r_hold  <= w_hold_next;
      r_error <= w_error_next;
    end
  end

  assign rx_byte_o  = r_rx_byte;
  assign shift_in_o = r_shift;
  assign ready_o    = r_ready;
  assign hold_o     = r_hold;
  assign error_o    = r_error;

endmodule : nonce_loader

// File: tb/tb_nonce_loader.sv
// Self-checking bench for nonce_loader: a frame-level reference model is
// compared against the DUT every cycle, and a shadow of the downstream nonce
// register is checked against hand-computed 96-bit values after each frame.
module tb_nonce_loader;

  localparam int unsigned NB    = 12;
  localparam logic [7:0]  START = 8'h4E;
  localparam int unsigned TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] rx_byte_o;
  logic       shift_in_o;
  logic       ready_o;
  logic       hold_o;
  logic       error_o;

  nonce_loader #(
    .NONCE_BYTES   (NB),
    .START_BYTE    (START),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_byte_i (rx_byte),
    .rx_valid_i(rx_valid),
    .rx_byte_o (rx_byte_o),
    .shift_in_o(shift_in_o),
    .ready_o   (ready_o),
    .hold_o    (hold_o),
    .error_o   (error_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: frame progress tracked as plain flags and integers.
  // Outputs it predicts are those visible during the cycle after each edge.
  // ---------------------------------------------------------------------
  bit         frame_open = 0;
  bit         finish_due = 0;
  int         taken      = 0;
  int         quiet      = 0;
  logic       exp_shift  = 0;
  logic       exp_ready  = 0;
  logic       exp_error  = 0;
  logic       exp_hold   = 0;
  logic [7:0] exp_byte   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_open = 0; finish_due = 0; taken = 0; quiet = 0;
      exp_shift = 0; exp_ready = 0; exp_error = 0; exp_hold = 0; exp_byte = 0;
    end else begin
      exp_shift = 0;
      exp_ready = 0;
      exp_error = 0;
      if (finish_due) begin
        exp_ready  = 1;
        finish_due = 0;
      end
      if (frame_open) begin
        if (rx_valid) begin
          exp_shift = 1;
          exp_byte  = rx_byte;
          taken++;
          quiet = 0;
          if (taken == NB) begin
            frame_open = 0;
            finish_due = 1;
          end
        end else begin
          quiet++;
          if (quiet == TMO) begin
            frame_open = 0;
            exp_error  = 1;
          end
        end
      end else if (rx_valid && rx_byte == START) begin
        frame_open = 1;
        taken      = 0;
        quiet      = 0;
      end
      exp_hold = frame_open || finish_due || exp_ready || exp_error;
    end
  end

  // ---------------------------------------------------------------------
  // Per-cycle compare plus a shadow of the downstream nonce register.
  // ---------------------------------------------------------------------
  bit          cmp_en    = 0;
  logic [95:0] shadow    = '0;
  logic [95:0] committed = '0;
  int          sh_cnt    = 0;
  int          rdy_cnt   = 0;
  int          err_cnt   = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cycle{hold,shift,ready,error,byte}",
            {84'd0, hold_o, shift_in_o, ready_o, error_o, rx_byte_o},
            {84'd0, exp_hold, exp_shift, exp_ready, exp_error, exp_byte});
      if (shift_in_o) begin
        shadow = {shadow[87:0], rx_byte_o};
        sh_cnt++;
      end
      if (ready_o) begin
        committed = shadow;
        rdy_cnt++;
      end
      if (error_o) err_cnt++;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------
  task automatic send(input logic v, input logic [7:0] b);
    rx_valid = v;
    rx_byte  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 8'h00);
  endtask

  task automatic payload(input logic [7:0] base);
    for (int i = 0; i < NB; i++) send(1'b1, base + 8'(i));
  endtask

  function automatic logic [95:0] outs();
    return {84'd0, hold_o, shift_in_o, ready_o, error_o, rx_byte_o};
  endfunction

  int s_sh, s_rdy, s_err, err_at;
  logic hold_after;

  initial begin
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    cmp_en = 1;
    check("reset_outputs", outs(), 96'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Full frame 00..0B.
    s_sh = sh_cnt; s_rdy = rdy_cnt;
    send(1'b1, START);
    payload(8'h00);
    idle(3);
    check("full_commit", committed, 96'h000102030405060708090A0B);
    check("full_shifts", 96'(sh_cnt - s_sh), 96'd12);
    check("full_ready", 96'(rdy_cnt - s_rdy), 96'd1);

    // Garbage ahead of the start byte is ignored.
    s_sh = sh_cnt;
    send(1'b1, 8'h41);
    send(1'b1, 8'h00);
    idle(1);
    check("garbage_no_shift", 96'(sh_cnt - s_sh), 96'd0);
    send(1'b1, START);
    payload(8'h10);
    idle(3);
    check("garbage_commit", committed, 96'h101112131415161718191A1B);
    check("garbage_shifts", 96'(sh_cnt - s_sh), 96'd12);

    // Start byte value used as payload.
    s_rdy = rdy_cnt;
    send(1'b1, START);
    for (int i = 0; i < NB; i++) send(1'b1, START);
    idle(3);
    check("start_in_payload_commit", committed, 96'h4E4E4E4E4E4E4E4E4E4E4E4E);
    check("start_in_payload_ready", 96'(rdy_cnt - s_rdy), 96'd1);

    // Timeout after five bytes, then a clean frame.
    s_rdy = rdy_cnt; s_err = err_cnt; err_at = 0; hold_after = 1'b1;
    send(1'b1, START);
    for (int i = 0; i < 5; i++) send(1'b1, 8'h30 + 8'(i));
    for (int i = 1; i <= 20; i++) begin
      send(1'b0, 8'h00);
      if (error_o && err_at == 0) err_at = i;
      if (i == TMO + 1) hold_after = hold_o;
    end
    check("timeout_idle_cycles", 96'(err_at), 96'd16);
    check("timeout_errors", 96'(err_cnt - s_err), 96'd1);
    check("timeout_no_ready", 96'(rdy_cnt - s_rdy), 96'd0);
    check("timeout_hold_drops", {95'd0, hold_after}, 96'd0);
    send(1'b1, START);
    payload(8'h40);
    idle(3);
    check("after_timeout_commit", committed, 96'h404142434445464748494A4B);
    check("after_timeout_ready", 96'(rdy_cnt - s_rdy), 96'd1);

    // New start byte arriving in the ready_o cycle.
    s_rdy = rdy_cnt;
    send(1'b1, START);
    payload(8'h50);
    send(1'b0, 8'h00);
    check("ready_cycle_ready", {95'd0, ready_o}, 96'd1);
    send(1'b1, START);
    payload(8'h60);
    idle(3);
    check("rearm_commit", committed, 96'h606162636465666768696A6B);
    check("rearm_ready", 96'(rdy_cnt - s_rdy), 96'd2);

    // Reset mid-frame after six payload bytes.
    send(1'b1, START);
    for (int i = 0; i < 6; i++) send(1'b1, 8'h70 + 8'(i));
    s_rdy = rdy_cnt; s_err = err_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 96'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    check("reset_no_ready", 96'(rdy_cnt - s_rdy), 96'd0);
    check("reset_no_error", 96'(err_cnt - s_err), 96'd0);
    s_rdy = rdy_cnt;
    send(1'b1, START);
    payload(8'hA0);
    idle(3);
    check("post_reset_commit", committed, 96'hA0A1A2A3A4A5A6A7A8A9AAAB);
    check("post_reset_ready", 96'(rdy_cnt - s_rdy), 96'd1);

    idle(2);
    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_nonce_loader
